ika9958_slot_sequencer: RTL and testbench
=========================================

Name: ika9958_slot_sequencer

Overview:
- Parametrised successor of the base PLA counter/decoder.
- A horizontal slot counter split into a pixel-in-tile field (lo) and a tile field (hi), with a tile length selectable at run time (graphics/text).
- Produces a registered one-hot cycle-in-tile vector, end-of-tile and end-of-line strobes, and N_WIN run-time-programmable set/clear window latches.
- Replaces hard-coded compare points; feeds the memory-slot PLA and display timing.

Parameters:
- CNT_W, 9, total counter width; hi field = CNT_W-LO_W bits.
- LO_W, 4, lo field width; must satisfy 2^LO_W >= TILE_A.
- TILE_A, 16, tile length when txt_mode=0 (graphics).
- TILE_B, 12, tile length when txt_mode=1 (text); must satisfy 2 <= TILE_B <= TILE_A.
- END_CNT, 9'h1FF, full count {hi,lo} at which the line wraps to 0.
- LOAD_VAL, 9'h1D3, value loaded on line_sync.
- N_WIN, 8, number of window latches; IW = max(1,$clog2(N_WIN)).

Ports:
- phiA, in, 1, master clock.
- RST, in, 1, synchronous active-high reset.
- phiL_NCEN, in, 1, clock enable; all state except the window-register file advances only when it is 1.
- txt_mode, in, 1, tile-length select (1 = TILE_B); sampled only at tile boundaries.
- line_sync, in, 1, restart pulse; loads LOAD_VAL.
- win_wr_en, in, 1, window register write strobe; ignores phiL_NCEN.
- win_wr_idx, in, IW, window index.
- win_wr_set, in, CNT_W, set compare point.
- win_wr_clr, in, CNT_W, clear compare point.
- win_wr_arm, in, 1, channel enable.
- cnt, out, CNT_W, current counter {hi,lo}.
- cyc, out, TILE_A, registered one-hot of the previous lo.
- eot, out, 1, registered end-of-tile strobe.
- line_end, out, 1, registered end-of-line strobe.
- win, out, N_WIN, window latch outputs.
- mode_q, out, 1, txt_mode value currently in effect.

Behaviour:
- Reset (RST=1 at a phiA edge, cen irrelevant):
  - cnt=0, cyc=0, eot=0, line_end=0, win=0, mode_q=0.
  - All window set/clr registers = 0; all arm bits = 0.
- Tile length: tlen = mode_q ? TILE_B : TILE_A.
- Combinational tile_last = (lo >= tlen-1). The >= comparison recovers an out-of-range lo left by a load.
- On each cen cycle, in priority order:
  1. If line_sync: cnt <= LOAD_VAL; no line_end pulse, even if cnt==END_CNT.
  2. Else if cnt==END_CNT: cnt <= 0; line_end <= 1 next cen cycle.
  3. Else if tile_last: lo <= 0; hi <= hi+1, wrapping modulo 2^(CNT_W-LO_W); mode_q <= txt_mode.
  4. Else: lo <= lo+1.
- Registered outputs (one cen of latency, all updated on the same edge as cnt):
  - eot <= tile_last & ~line_sync.
  - line_end <= (cnt==END_CNT) & ~line_sync.
  - cyc <= one-hot(lo). All-zero if lo >= TILE_A, which is unreachable when parameters are legal.
- txt_mode changes mid-tile have no effect until the next tile_last cycle.
- Window channel k, updated on cen cycles only:
  - hit_s = arm[k] & (cnt==set[k]); hit_c = arm[k] & (cnt==clr[k]).
  - win[k] <= hit_c ? 0 : hit_s ? 1 : win[k]. Clear wins when set==clr.
  - arm[k]=0 forces win[k] <= 0 on the next cen cycle.
  - Compares use the pre-update cnt, so win rises one cen after cnt equals the set point.
- Window writes:
  - A write of index k takes effect on the next phiA edge.
  - A write during a cen cycle uses the old values for that cycle's compare.
  - Writes with win_wr_idx >= N_WIN are ignored.
  - RST has priority over writes.
- With phiL_NCEN=0, every output holds its value.

Test Plan:
1. Reset, then 40 cen cycles with txt_mode=0 -> cnt runs 0..0x27; eot high on the cycles after lo=15 (cnt 0x010, 0x020); cyc one-hot tracks lo-1.
2. Raise txt_mode at cnt=0x013 -> lo continues to 15; mode_q=1 only from cnt=0x020; the next tile wraps after lo=11 (0x02B -> 0x030).
3. line_sync pulse at cnt=0x055 -> next cnt=0x1D3, no line_end. Then free-run at TILE_A to 0x1FF -> cnt=0, line_end=1 for one cen.
4. Program win[2] set=0x010, clr=0x018, arm=1 -> win[2] high for cen cycles where cnt=0x011..0x018, low when cnt=0x019.
5. Program win[0] with set=clr=0x020 -> win[0] stays 0. Disarm win[2] mid-window -> win[2]=0 the next cen.
6. Hold phiL_NCEN=0 for 5 cycles mid-line -> all outputs frozen. Assert RST with phiL_NCEN=0 -> everything zero on the next edge, arm bits cleared.

Source files
------------

// File: rtl/ika9958_slot_sequencer.sv
// Horizontal slot sequencer: tile/line counter with run-time tile length, registered
// cycle-in-tile decode, end-of-tile/end-of-line strobes and programmable window latches.
module ika9958_slot_sequencer #(
    parameter int unsigned    CNT_W    = 9,
    parameter int unsigned    LO_W     = 4,
    parameter int unsigned    TILE_A   = 16,
    parameter int unsigned    TILE_B   = 12,
    parameter logic [CNT_W-1:0] END_CNT  = 9'h1FF,
    parameter logic [CNT_W-1:0] LOAD_VAL = 9'h1D3,
    parameter int unsigned    N_WIN    = 8,
    localparam int unsigned   IW       = (N_WIN > 1) ? $clog2(N_WIN) : 1
) (
    input  logic              phiA,
    input  logic              RST,
    input  logic              phiL_NCEN,
    input  logic              txt_mode,
    input  logic              line_sync,
    input  logic              win_wr_en,
    input  logic [IW-1:0]     win_wr_idx,
    input  logic [CNT_W-1:0]  win_wr_set,
    input  logic [CNT_W-1:0]  win_wr_clr,
    input  logic              win_wr_arm,
    output logic [CNT_W-1:0]  cnt,
    output logic [TILE_A-1:0] cyc,
    output logic              eot,
    output logic              line_end,
    output logic [N_WIN-1:0]  win,
    output logic              mode_q
);

    localparam int unsigned HI_W = CNT_W - LO_W;
    localparam logic [LO_W-1:0] TA_LAST = LO_W'(TILE_A - 1);
    localparam logic [LO_W-1:0] TB_LAST = LO_W'(TILE_B - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TILE_A-1:0] cyc_q, cyc_d;
    logic              eot_q, eot_d;
    logic              line_end_q, line_end_d;
    logic              mode_sel_q, mode_sel_d;
    logic [N_WIN-1:0]  win_q, win_d;

    logic [N_WIN-1:0][CNT_W-1:0] set_q, set_d;
    logic [N_WIN-1:0][CNT_W-1:0] clr_q, clr_d;
    logic [N_WIN-1:0]            arm_q, arm_d;

    logic [LO_W-1:0] lo;
    logic [HI_W-1:0] hi;
    logic            tile_last;
    logic            at_end;

    assign lo        = cnt_q[LO_W-1:0];
    assign hi        = cnt_q[CNT_W-1:LO_W];
    // >= rather than == so a load that lands past the tile end still wraps
    assign tile_last = lo >= (mode_sel_q ? TB_LAST : TA_LAST);
    assign at_end    = cnt_q == END_CNT;

    always_comb begin
        cnt_d      = cnt_q;
        cyc_d      = cyc_q;
        eot_d      = eot_q;
        line_end_d = line_end_q;
        mode_sel_d = mode_sel_q;
        win_d      = win_q;
        if (phiL_NCEN) begin
            eot_d      = tile_last & ~line_sync;
            line_end_d = at_end & ~line_sync;
            for (int unsigned i = 0; i < TILE_A; i++) begin
                cyc_d[i] = lo == LO_W'(i);
            end
            if (line_sync) begin
                cnt_d = LOAD_VAL;
            end else if (at_end) begin
                cnt_d = '0;
            end else if (tile_last) begin
                cnt_d      = {hi + HI_W'(1), {LO_W{1'b0}}};
                mode_sel_d = txt_mode;
            end else begin
                cnt_d = {hi, lo + LO_W'(1)};
            end
            // Compares see the pre-update count and pre-write registers
            for (int unsigned k = 0; k < N_WIN; k++) begin
                if (!arm_q[k]) begin
                    win_d[k] = 1'b0;
                end else if (cnt_q == clr_q[k]) begin
                    win_d[k] = 1'b0;
                end else if (cnt_q == set_q[k]) begin
                    win_d[k] = 1'b1;
                end
            end
        end
    end

    // Register-file writes ignore the clock enable; out-of-range indices match no channel
    always_comb begin
        set_d = set_q;
        clr_d = clr_q;
        arm_d = arm_q;
        for (int unsigned k = 0; k < N_WIN; k++) begin
            if (win_wr_en && (win_wr_idx == IW'(k))) begin
                set_d[k] = win_wr_set;
                clr_d[k] = win_wr_clr;
                arm_d[k] = win_wr_arm;
            end
        end
    end

    always_ff @(posedge phiA) begin
        if (RST) begin
            cnt_q      <= '0;
            cyc_q      <= '0;
            eot_q      <= 1'b0;
            line_end_q <= 1'b0;
            mode_sel_q <= 1'b0;
            win_q      <= '0;
            set_q      <= '0;
            clr_q      <= '0;
            arm_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            cyc_q      <= cyc_d;
            eot_q      <= eot_d;
            line_end_q <= line_end_d;
            mode_sel_q <= mode_sel_d;
            win_q      <= win_d;
            set_q      <= set_d;
            clr_q      <= clr_d;
            arm_q      <= arm_d;
        end
    end

    assign cnt      = cnt_q;
    assign cyc      = cyc_q;
    assign eot      = eot_q;
    assign line_end = line_end_q;
    assign win      = win_q;
    assign mode_q   = mode_sel_q;

endmodule

// File: tb/tb_ika9958_slot_sequencer.sv
// Bench for ika9958_slot_sequencer: directed steps plus random traffic, compared every
// clock against an arithmetic model of the slot counter and window channels.
module tb_ika9958_slot_sequencer;

    logic        clk = 1'b0;
    logic        rst, cen, txt, sync, wr_en, wr_arm;
    logic [2:0]  wr_idx;
    logic [8:0]  wr_set, wr_clr;
    logic [8:0]  cnt;
    logic [15:0] cyc;
    logic        eot, line_end, mode_q;
    logic [7:0]  win;

    always #5 clk = ~clk;

    ika9958_slot_sequencer dut (
        .phiA      (clk),
        .RST       (rst),
        .phiL_NCEN (cen),
        .txt_mode  (txt),
        .line_sync (sync),
        .win_wr_en (wr_en),
        .win_wr_idx(wr_idx),
        .win_wr_set(wr_set),
        .win_wr_clr(wr_clr),
        .win_wr_arm(wr_arm),
        .cnt       (cnt),
        .cyc       (cyc),
        .eot       (eot),
        .line_end  (line_end),
        .win       (win),
        .mode_q    (mode_q)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_cnt, m_mode, m_eot, m_le;
    logic [15:0] m_cyc;
    logic [7:0]  m_win;
    int          m_set[8], m_clr[8];
    bit          m_arm[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int lo, hi, tlen;
        bit last;
        if (rst) begin
            m_cnt = 0; m_mode = 0; m_eot = 0; m_le = 0; m_cyc = '0; m_win = '0;
            for (int k = 0; k < 8; k++) begin
                m_set[k] = 0; m_clr[k] = 0; m_arm[k] = 0;
            end
            return;
        end
        if (cen) begin
            lo   = m_cnt % 16;
            hi   = m_cnt / 16;
            tlen = (m_mode != 0) ? 12 : 16;
            last = lo >= tlen - 1;
            for (int k = 0; k < 8; k++) begin
                if (!m_arm[k] || m_cnt == m_clr[k]) m_win[k] = 1'b0;
                else if (m_cnt == m_set[k])        m_win[k] = 1'b1;
            end
            m_eot = (last && !sync) ? 1 : 0;
            m_le  = (m_cnt == 511 && !sync) ? 1 : 0;
            m_cyc = 16'(1) << lo;
            if (sync)              m_cnt = 'h1D3;
            else if (m_cnt == 511) m_cnt = 0;
            else if (last) begin
                m_cnt  = ((hi + 1) % 32) * 16;
                m_mode = txt;
            end else               m_cnt = m_cnt + 1;
        end
        if (wr_en) begin
            m_set[wr_idx] = wr_set;
            m_clr[wr_idx] = wr_clr;
            m_arm[wr_idx] = wr_arm;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("cnt", 32'(cnt), 32'(m_cnt));
        chk("cyc", 32'(cyc), 32'(m_cyc));
        chk("eot", 32'(eot), 32'(m_eot));
        chk("line_end", 32'(line_end), 32'(m_le));
        chk("win", 32'(win), 32'(m_win));
        chk("mode_q", 32'(mode_q), 32'(m_mode));
    endtask

    task automatic run_until(input int target, input int bound);
        int n = 0;
        while (m_cnt != target && n < bound) begin
            step();
            n++;
        end
        chk("reach", 32'(cnt), 32'(target));
    endtask

    task automatic wr(input int idx, input int s, input int c, input bit a);
        wr_en = 1'b1; wr_idx = 3'(idx); wr_set = 9'(s); wr_clr = 9'(c); wr_arm = a;
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; txt = 1'b0; sync = 1'b0;
        wr_en = 1'b0; wr_idx = '0; wr_set = '0; wr_clr = '0; wr_arm = 1'b0;
        #2;
        step();
        chk("rst_cnt", 32'(cnt), 32'h0);
        chk("rst_win", 32'(win), 32'h0);
        rst = 1'b0;
        cen = 1'b1;

        // Graphics tiles
        run_until('h010, 40);
        chk("eot_gfx", 32'(eot), 32'h1);
        chk("cyc_gfx", 32'(cyc), 32'h8000);
        run_until('h013, 10);

        // Text mode takes effect only at the next tile boundary
        txt = 1'b1;
        run_until('h01F, 20);
        chk("mode_mid", 32'(mode_q), 32'h0);
        step();
        chk("mode_new", 32'(mode_q), 32'h1);
        run_until('h02B, 20);
        step();
        chk("txt_wrap", 32'(cnt), 32'h030);
        chk("txt_eot", 32'(eot), 32'h1);
        chk("txt_cyc", 32'(cyc), 32'h0800);
        txt = 1'b0;

        // line_sync load and end-of-line wrap
        run_until('h055, 100);
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_load", 32'(cnt), 32'h1D3);
        chk("sync_no_le", 32'(line_end), 32'h0);
        run_until('h1FF, 100);
        step();
        chk("wrap_cnt", 32'(cnt), 32'h0);
        chk("wrap_le", 32'(line_end), 32'h1);
        step();
        chk("le_pulse", 32'(line_end), 32'h0);

        // Window 2: set 0x010, clear 0x018
        cen = 1'b0;
        wr(2, 'h010, 'h018, 1'b1);
        step();
        wr_en = 1'b0;
        cen = 1'b1;
        run_until('h011, 40);
        chk("win2_rise", 32'(win[2]), 32'h1);
        run_until('h018, 20);
        chk("win2_hold", 32'(win[2]), 32'h1);
        step();
        chk("win2_fall", 32'(win[2]), 32'h0);

        // set==clr never opens; disarm mid-window
        cen = 1'b0;
        wr(0, 'h020, 'h020, 1'b1);
        step();
        wr(2, 'h030, 'h03F, 1'b1);
        step();
        wr_en = 1'b0;
        cen = 1'b1;
        run_until('h024, 40);
        chk("win0_eq", 32'(win[0]), 32'h0);
        run_until('h034, 40);
        chk("win2_open", 32'(win[2]), 32'h1);
        wr(2, 'h030, 'h03F, 1'b0);
        step();
        wr_en = 1'b0;
        chk("win2_old", 32'(win[2]), 32'h1);
        step();
        chk("win2_disarm", 32'(win[2]), 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cen  = ($urandom_range(0, 7) != 0);
            sync = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 15) == 0) txt = ~txt;
            if ($urandom_range(0, 5) == 0) begin
                wr($urandom_range(0, 7), (m_cnt + $urandom_range(1, 12)) % 512,
                   (m_cnt + $urandom_range(1, 30)) % 512, ($urandom_range(0, 4) != 0));
            end else begin
                wr_en = 1'b0;
            end
            step();
        end
        wr_en = 1'b0;
        sync  = 1'b0;

        // Clock-enable hold
        cen = 1'b1;
        step();
        begin
            int          saved_cnt;
            logic [15:0] saved_cyc;
            saved_cnt = m_cnt;
            saved_cyc = m_cyc;
            cen = 1'b0;
            repeat (5) step();
            chk("hold_cnt", 32'(cnt), 32'(saved_cnt));
            chk("hold_cyc", 32'(cyc), 32'(saved_cyc));
        end

        // Reset while disabled clears everything, including arm bits
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_cnt", 32'(cnt), 32'h0);
        chk("rst2_win", 32'(win), 32'h0);
        cen = 1'b1;
        repeat (40) step();
        chk("rst2_noarm", 32'(win), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
